// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and types for the pipeline stage register slice.
package pipe_stage_reg_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;

  // ExcCode meaning "no exception" and the exception vector PC.
  localparam logic [EXC_W-1:0] EXCNO = 5'd0;
  localparam logic [XLEN-1:0]  EXCPC = 32'h0000_4180;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: instr/pc/data/exc/bd register with load enable.
module pipe_entry
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned      DATA_W  = 96,
  parameter logic [XLEN-1:0]  PC_RST  = '0,
  parameter logic [EXC_W-1:0] EXC_RST = EXCNO
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [XLEN-1:0]   in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  output logic [XLEN-1:0]   out_instr,
  output logic [XLEN-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd
);

  // Capture all fields together when load is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_instr <= '0;
      out_pc    <= PC_RST;
      out_data  <= '0;
      out_exc   <= EXC_RST;
      out_bd    <= 1'b0;
    end else if (load) begin
      out_instr <= in_instr;
      out_pc    <= in_pc;
      out_data  <= in_data;
      out_exc   <= in_exc;
      out_bd    <= in_bd;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (head + skid) pipeline stage register with stall, flush and
// bubble PC/BD tracking for EPC reporting.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned      DATA_W   = 96,
  parameter logic [XLEN-1:0]  PC_RST   = 32'h0000_0000,
  parameter logic [XLEN-1:0]  EXC_PC   = EXCPC,
  parameter logic [EXC_W-1:0] EXC_NONE = EXCNO
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_instr,
  output logic [XLEN-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic [1:0]        occ
);

  stage_state_e state_q;
  logic [XLEN-1:0] bub_pc_q;
  logic            bub_bd_q;

  logic push, pop, head_load, skid_load, head_from_skid, goes_empty;

  logic [XLEN-1:0]   hd_instr, hd_pc, hq_instr, hq_pc, sq_instr, sq_pc;
  logic [DATA_W-1:0] hd_data, hq_data, sq_data;
  logic [EXC_W-1:0]  hd_exc, hq_exc, sq_exc;
  logic              hd_bd, hq_bd, sq_bd;

  assign in_ready  = (state_q != StTwo) && !stall && !req;
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occ       = state_q;

  // Decode entry load enables and whether the stage ends this cycle empty.
  always_comb begin
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_from_skid = (state_q == StTwo);
    goes_empty     = 1'b0;
    if (!req) begin
      unique case (state_q)
        StEmpty: begin
          head_load  = push;
          goes_empty = !push;
        end
        StOne: begin
          head_load  = push && pop;
          skid_load  = push && !pop;
          goes_empty = pop && !push;
        end
        StTwo: head_load = pop;
        default: ;
      endcase
    end
  end

  // Head refills from the skid when draining TWO, otherwise from the input.
  assign hd_instr = head_from_skid ? sq_instr : in_instr;
  assign hd_pc    = head_from_skid ? sq_pc    : in_pc;
  assign hd_data  = head_from_skid ? sq_data  : in_data;
  assign hd_exc   = head_from_skid ? sq_exc   : in_exc;
  assign hd_bd    = head_from_skid ? sq_bd    : in_bd;

  // Occupancy FSM plus bubble PC/BD; flush wins over every other event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StEmpty;
      bub_pc_q <= PC_RST;
      bub_bd_q <= 1'b0;
    end else if (req) begin
      state_q  <= StEmpty;
      bub_pc_q <= EXC_PC;
      bub_bd_q <= 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: if (push) state_q <= StOne;
        StOne: begin
          if (push && !pop)      state_q <= StTwo;
          else if (pop && !push) state_q <= StEmpty;
        end
        StTwo:   if (pop) state_q <= StOne;
        default: state_q <= StEmpty;
      endcase
      // A stalled bubble inherits the stalled instruction's PC/BD.
      if (stall && goes_empty) begin
        bub_pc_q <= in_pc;
        bub_bd_q <= in_bd;
      end
    end
  end

  pipe_entry #(
    .DATA_W  (DATA_W),
    .PC_RST  (PC_RST),
    .EXC_RST (EXC_NONE)
  ) u_head (
    .clk       (clk),
    .reset     (reset),
    .load      (head_load),
    .in_instr  (hd_instr),
    .in_pc     (hd_pc),
    .in_data   (hd_data),
    .in_exc    (hd_exc),
    .in_bd     (hd_bd),
    .out_instr (hq_instr),
    .out_pc    (hq_pc),
    .out_data  (hq_data),
    .out_exc   (hq_exc),
    .out_bd    (hq_bd)
  );

  pipe_entry #(
    .DATA_W  (DATA_W),
    .PC_RST  (PC_RST),
    .EXC_RST (EXC_NONE)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .in_exc    (in_exc),
    .in_bd     (in_bd),
    .out_instr (sq_instr),
    .out_pc    (sq_pc),
    .out_data  (sq_data),
    .out_exc   (sq_exc),
    .out_bd    (sq_bd)
  );

  // Outputs come only from registers; an empty stage shows a bubble.
  assign out_instr = out_valid ? hq_instr : '0;
  assign out_data  = out_valid ? hq_data  : '0;
  assign out_exc   = out_valid ? hq_exc   : EXC_NONE;
  assign out_pc    = out_valid ? hq_pc    : bub_pc_q;
  assign out_bd    = out_valid ? hq_bd    : bub_bd_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 96: width of the opaque payload (operands, immediate, control bits).
REQ-002 Parameter PC_RST, default 32'h0000_0000: out_pc value after reset.
REQ-003 Parameter EXC_PC, default 32'h0000_4180: out_pc value after an exception redirect.
REQ-004 Parameter EXC_NONE, default 5'd0: ExcCode meaning "no exception".
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 reset  in  1  one clock; reset is asynchronous and active-high.
REQ-007 req  in  1  exception redirect; flushes the stage.
REQ-008 stall  in  1  hazard stall; blocks acceptance and marks the next bubble.
REQ-009 in_valid  in  1  upstream offers an instruction.
REQ-010 in_ready  out  1  stage can accept the offered instruction.
REQ-011 in_instr, in_pc  in  32 each  instruction word and PC.
REQ-012 in_data  in  DATA_W  payload.
REQ-013 in_exc  in  5  ExcCode carried with the instruction.
REQ-014 in_bd  in  1  instruction is in a branch-delay slot.
REQ-015 out_valid  out  1  head entry holds a real instruction.
REQ-016 out_ready  in  1  downstream consumes the head entry this cycle.
REQ-017 out_instr, out_pc, out_data, out_exc, out_bd  out  widths as in_*  head entry fields.
REQ-018 occ  out  2  occupancy: 0, 1 or 2.

Function
REQ-019 Storage SHALL be two entries, head (drives out_*) and skid; states EMPTY (occ=0), ONE (occ=1), TWO (occ=2).
REQ-020 in_ready SHALL equal (state!=TWO) && !stall && !req, combinationally.
REQ-021 A push SHALL occur when in_valid && in_ready; a pop SHALL occur when out_valid && out_ready.
REQ-022 Transitions: EMPTY+push->ONE, head<=in; ONE+push+pop->ONE, head<=in; ONE+push->TWO, skid<=in; ONE+pop->EMPTY; TWO+pop->ONE, head<=skid; no event->hold.
REQ-023 Latency SHALL be one cycle: an instruction pushed into an empty stage appears on out_* with out_valid=1 in the next cycle.
REQ-024 While EMPTY, out_valid=0, out_instr=0, out_data=0, out_exc=EXC_NONE; out_pc/out_bd SHALL show the bubble PC/BD.
REQ-025 Bubble PC/BD SHALL be captured from in_pc/in_bd on every cycle where stall=1 and the stage would become or remain EMPTY, so the bubble carries the stalled instruction's PC and BD flag for EPC.
REQ-026 When the stage becomes EMPTY by pop without stall, bubble PC/BD SHALL hold their previous values.
REQ-027 req=1 SHALL have highest priority: next state EMPTY, both entries discarded, no push or pop, bubble PC<=EXC_PC, bubble BD<=0.
REQ-028 stall=1 SHALL NOT block a pop; the head drains normally during stall.
REQ-029 out_* SHALL be driven only from registers (no in_* to out_* combinational path); in_ready depends only on state, stall and req.
REQ-030 A push with in_valid=1 while in_ready=0 SHALL be ignored; upstream holds its data.

Reset
REQ-031 On reset assertion, asynchronously: state=EMPTY, occ=0, out_valid=0, out_instr=0, out_data=0, out_exc=EXC_NONE, out_pc=PC_RST, out_bd=0, skid cleared.
REQ-032 Reset SHALL override req, stall, push and pop; an entry in flight during reset is lost.

Structure
REQ-033 EXC_NONE and EXC_PC default values SHALL come from the shared header constants (EXCNO, EXCPC).
REQ-034 The ExcCode width (5) and instruction/PC width (32) SHALL be shared package constants.
REQ-035 One sub-module, pipe_entry (a register of instr/pc/data/exc/bd with load enable), SHALL be instantiated for head and skid.

Verification
REQ-036 Reset mid-stream with occ=2 -> immediately occ=0, out_valid=0, out_pc=PC_RST, out_exc=EXC_NONE.
REQ-037 Push pc=0x3000 into EMPTY with out_ready=1 -> next cycle out_valid=1, out_pc=0x3000; following cycle EMPTY.
REQ-038 out_ready=0 with two pushes (pc 0x3000, 0x3004) -> occ=2, in_ready=0, third offer ignored; then out_ready=1 -> heads 0x3000 then 0x3004 in order.
REQ-039 stall=1 with in_pc=0x3008, in_bd=1, stage draining -> out_valid=0, out_instr=0, out_pc=0x3008, out_bd=1.
REQ-040 req=1 with occ=2 and in_valid=1 -> next cycle occ=0, out_pc=0x4180, out_bd=0, in_ready=0 during req.
REQ-041 ONE with push and pop on the same cycle -> occ stays 1, head replaced by the new entry, no loss or duplication.
